// File: rtl/ctrl_pkg.sv
// Shared control definitions for the pipelined decoder: opcodes, ALUOp and
// forwarding encodings, per-stage control bundles and the decode helpers.
package ctrl_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   typedef enum logic [1:0] {
      ADD_OPCODE    = 2'b00,
      SUB_OPCODE    = 2'b01,
      R_TYPE_OPCODE = 2'b10
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_RF     = 2'b00,
      FWD_MEM_WB = 2'b01,
      FWD_EX_MEM = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      alu_op_e alu_op;
      logic    alu_src;
      logic    branch;
      logic    jump;
      logic    mem_read;
      logic    mem_write;
      logic    reg_write;
      logic    mem_2_reg;
   } ctrl_bundle;

   // Later stages only keep the fields they still consume.
   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic reg_write;
      logic mem_2_reg;
   } mem_ctrl_t;

   typedef struct packed {
      logic reg_write;
      logic mem_2_reg;
   } wb_ctrl_t;

   localparam ctrl_bundle BUBBLE = '{alu_op: ADD_OPCODE, alu_src: 1'b0, branch: 1'b0,
                                     jump: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                     reg_write: 1'b0, mem_2_reg: 1'b0};

   function automatic ctrl_bundle decode(input logic [6:0] op);
      ctrl_bundle c;
      c = BUBBLE;
      case (op)
         OP_R:     begin c.reg_write = 1'b1; c.alu_op = R_TYPE_OPCODE; end
         OP_I:     begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
         OP_LOAD:  begin
            c.alu_src   = 1'b1;
            c.mem_2_reg = 1'b1;
            c.reg_write = 1'b1;
            c.mem_read  = 1'b1;
         end
         OP_STORE: begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
         OP_BEQ:   begin c.branch = 1'b1; c.alu_op = SUB_OPCODE; end
         OP_JAL:   begin c.reg_write = 1'b1; c.jump = 1'b1; end
         default:  c = BUBBLE;
      endcase
      return c;
   endfunction

   function automatic logic uses_rs1(input logic [6:0] op);
      return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BEQ};
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return op inside {OP_R, OP_STORE, OP_BEQ};
   endfunction

endpackage

// File: rtl/pipe_control_unit_if.sv
// ID-stage request fields and per-stage control/hazard outputs of the
// pipeline control unit.
interface pipe_control_unit_if #(parameter int REG_ADDR_W = 5);

   logic [6:0]            opcode_id;
   logic [REG_ADDR_W-1:0] rs1_id;
   logic [REG_ADDR_W-1:0] rs2_id;
   logic [REG_ADDR_W-1:0] rd_id;
   logic                  flush_ex;

   logic [1:0]            alu_op_ex;
   logic                  alu_src_ex;
   logic                  branch_ex;
   logic                  jump_ex;
   logic                  mem_read_mem;
   logic                  mem_write_mem;
   logic                  reg_write_wb;
   logic                  mem_2_reg_wb;
   logic [REG_ADDR_W-1:0] rd_wb;
   logic [1:0]            forward_a_ex;
   logic [1:0]            forward_b_ex;
   logic                  pc_write;
   logic                  if_id_write;
   logic                  if_id_flush;

   modport master (
      output opcode_id, rs1_id, rs2_id, rd_id, flush_ex,
      input  alu_op_ex, alu_src_ex, branch_ex, jump_ex, mem_read_mem, mem_write_mem,
             reg_write_wb, mem_2_reg_wb, rd_wb, forward_a_ex, forward_b_ex,
             pc_write, if_id_write, if_id_flush
   );

   modport slave (
      input  opcode_id, rs1_id, rs2_id, rd_id, flush_ex,
      output alu_op_ex, alu_src_ex, branch_ex, jump_ex, mem_read_mem, mem_write_mem,
             reg_write_wb, mem_2_reg_wb, rd_wb, forward_a_ex, forward_b_ex,
             pc_write, if_id_write, if_id_flush
   );

endinterface

// File: rtl/hazard_forward_unit.sv
// Combinational stall / flush / forwarding-select logic. With FWD_EN=0 every
// RAW dependency on ID/EX or EX/MEM stalls and forwarding is disabled.
module hazard_forward_unit
   import ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter bit FWD_EN     = 1'b1
) (
   input  logic                  use_rs1_id,
   input  logic                  use_rs2_id,
   input  logic [REG_ADDR_W-1:0] rs1_id,
   input  logic [REG_ADDR_W-1:0] rs2_id,
   input  logic                  mem_read_ex,
   input  logic                  reg_write_ex,
   input  logic [REG_ADDR_W-1:0] rd_ex,
   input  logic [REG_ADDR_W-1:0] rs1_ex,
   input  logic [REG_ADDR_W-1:0] rs2_ex,
   input  logic                  reg_write_mem,
   input  logic [REG_ADDR_W-1:0] rd_mem,
   input  logic                  reg_write_wb,
   input  logic [REG_ADDR_W-1:0] rd_wb,
   input  logic                  flush,
   output logic                  bubble_ex,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  if_id_flush,
   output fwd_sel_e              forward_a,
   output fwd_sel_e              forward_b
);

   function automatic logic src_hit(input logic [REG_ADDR_W-1:0] rd);
      return (rd != '0) && ((use_rs1_id && rd == rs1_id) || (use_rs2_id && rd == rs2_id));
   endfunction

   function automatic fwd_sel_e fwd(input logic [REG_ADDR_W-1:0] rs);
      if (reg_write_mem && rd_mem != '0 && rd_mem == rs)     return FWD_EX_MEM;
      else if (reg_write_wb && rd_wb != '0 && rd_wb == rs)   return FWD_MEM_WB;
      else                                                   return FWD_RF;
   endfunction

   logic hit_ex, hit_mem, stall;

   assign hit_ex  = src_hit(rd_ex);
   assign hit_mem = src_hit(rd_mem);

   assign stall = FWD_EN ? (mem_read_ex & hit_ex)
                         : ((reg_write_ex & hit_ex) | (reg_write_mem & hit_mem));

   // A taken branch/jump kills the dependent instruction anyway, so flush wins.
   assign pc_write    = ~stall | flush;
   assign if_id_write = ~stall | flush;
   assign if_id_flush = flush;
   assign bubble_ex   = stall | flush;

   assign forward_a = FWD_EN ? fwd(rs1_ex) : FWD_RF;
   assign forward_b = FWD_EN ? fwd(rs2_ex) : FWD_RF;

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decodes the ID opcode and carries the control
// bundle through ID/EX, EX/MEM and MEM/WB, with hazard and forwarding logic.
module pipe_control_unit
   import ctrl_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter bit FWD_EN     = 1'b1
) (
   input logic                clk,
   input logic                arst_n,
   input logic                enable,
   pipe_control_unit_if.slave bus
);

   ctrl_bundle            ctrl_id, ctrl_ex;
   mem_ctrl_t             ctrl_mem;
   wb_ctrl_t              ctrl_wb;
   logic [REG_ADDR_W-1:0] rd_ex, rd_mem, rd_wb, rs1_ex, rs2_ex;
   logic                  bubble_ex, flush;
   fwd_sel_e              forward_a, forward_b;

   assign ctrl_id = decode(bus.opcode_id);

   // Flush is masked during reset so that if_id_flush reads 0 there.
   assign flush = bus.flush_ex & arst_n;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         ctrl_ex  <= BUBBLE;
         ctrl_mem <= '0;
         ctrl_wb  <= '0;
         rd_ex    <= '0;
         rd_mem   <= '0;
         rd_wb    <= '0;
         rs1_ex   <= '0;
         rs2_ex   <= '0;
      end else if (enable) begin
         if (bubble_ex) begin
            ctrl_ex <= BUBBLE;
            rd_ex   <= '0;
            rs1_ex  <= '0;
            rs2_ex  <= '0;
         end else begin
            ctrl_ex <= ctrl_id;
            rd_ex   <= bus.rd_id;
            rs1_ex  <= bus.rs1_id;
            rs2_ex  <= bus.rs2_id;
         end
         ctrl_mem <= '{mem_read: ctrl_ex.mem_read, mem_write: ctrl_ex.mem_write,
                       reg_write: ctrl_ex.reg_write, mem_2_reg: ctrl_ex.mem_2_reg};
         rd_mem   <= rd_ex;
         ctrl_wb  <= '{reg_write: ctrl_mem.reg_write, mem_2_reg: ctrl_mem.mem_2_reg};
         rd_wb    <= rd_mem;
      end
   end

   hazard_forward_unit #(
      .REG_ADDR_W(REG_ADDR_W),
      .FWD_EN    (FWD_EN)
   ) u_hazard (
      .use_rs1_id   (uses_rs1(bus.opcode_id)),
      .use_rs2_id   (uses_rs2(bus.opcode_id)),
      .rs1_id       (bus.rs1_id),
      .rs2_id       (bus.rs2_id),
      .mem_read_ex  (ctrl_ex.mem_read),
      .reg_write_ex (ctrl_ex.reg_write),
      .rd_ex        (rd_ex),
      .rs1_ex       (rs1_ex),
      .rs2_ex       (rs2_ex),
      .reg_write_mem(ctrl_mem.reg_write),
      .rd_mem       (rd_mem),
      .reg_write_wb (ctrl_wb.reg_write),
      .rd_wb        (rd_wb),
      .flush        (flush),
      .bubble_ex    (bubble_ex),
      .pc_write     (bus.pc_write),
      .if_id_write  (bus.if_id_write),
      .if_id_flush  (bus.if_id_flush),
      .forward_a    (forward_a),
      .forward_b    (forward_b)
   );

   assign bus.alu_op_ex     = ctrl_ex.alu_op;
   assign bus.alu_src_ex    = ctrl_ex.alu_src;
   assign bus.branch_ex     = ctrl_ex.branch;
   assign bus.jump_ex       = ctrl_ex.jump;
   assign bus.mem_read_mem  = ctrl_mem.mem_read;
   assign bus.mem_write_mem = ctrl_mem.mem_write;
   assign bus.reg_write_wb  = ctrl_wb.reg_write;
   assign bus.mem_2_reg_wb  = ctrl_wb.mem_2_reg;
   assign bus.rd_wb         = rd_wb;
   assign bus.forward_a_ex  = forward_a;
   assign bus.forward_b_ex  = forward_b;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench: one forwarding and one non-forwarding instance share the
// same ID-stage stimulus; expected values are hand-computed per step.
module tb_pipe_control_unit;

   localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011, BEQ = 7'b1100011, JAL = 7'b1101111;
   localparam logic [6:0] ILL = 7'b1111111, NOP = 7'b0000000;

   logic       clk = 1'b0;
   logic       arst_n = 1'b0;
   logic       enable = 1'b1;
   logic [6:0] opcode = NOP;
   logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
   logic       flush = 1'b0;
   int         n_tests = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   pipe_control_unit_if #(.REG_ADDR_W(5)) bus_f ();
   pipe_control_unit_if #(.REG_ADDR_W(5)) bus_n ();

   assign bus_f.opcode_id = opcode;
   assign bus_f.rs1_id    = rs1;
   assign bus_f.rs2_id    = rs2;
   assign bus_f.rd_id     = rd;
   assign bus_f.flush_ex  = flush;
   assign bus_n.opcode_id = opcode;
   assign bus_n.rs1_id    = rs1;
   assign bus_n.rs2_id    = rs2;
   assign bus_n.rd_id     = rd;
   assign bus_n.flush_ex  = flush;

   pipe_control_unit #(.REG_ADDR_W(5), .FWD_EN(1'b1)) dut_f (
      .clk(clk), .arst_n(arst_n), .enable(enable), .bus(bus_f.slave));
   pipe_control_unit #(.REG_ADDR_W(5), .FWD_EN(1'b0)) dut_n (
      .clk(clk), .arst_n(arst_n), .enable(enable), .bus(bus_n.slave));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2);
      opcode = op; rd = d; rs1 = s1; rs2 = s2;
      #1;
   endtask

   task automatic drain();
      set_id(NOP, 0, 0, 0);
      repeat (3) tick();
   endtask

   initial begin
      // reset state, with flush_ex held high to check it is masked
      flush = 1'b1;
      #2;
      chk("rst_pc_write", bus_f.pc_write, 1);
      chk("rst_if_id_write", bus_f.if_id_write, 1);
      chk("rst_if_id_flush", bus_f.if_id_flush, 0);
      chk("rst_alu_op", bus_f.alu_op_ex, 0);
      chk("rst_reg_write_wb", bus_f.reg_write_wb, 0);
      chk("rst_fwd_a", bus_f.forward_a_ex, 0);
      flush = 1'b0;
      tick();
      arst_n = 1'b1;

      // decode: LOAD rd=5, then independent R
      set_id(LD, 5, 1, 0);
      tick();
      chk("ld_alu_src_ex", bus_f.alu_src_ex, 1);
      chk("ld_alu_op_ex", bus_f.alu_op_ex, 0);
      set_id(R, 6, 2, 8);
      chk("indep_pc_write", bus_f.pc_write, 1);
      tick();
      chk("ld_mem_read_mem", bus_f.mem_read_mem, 1);
      chk("r_alu_op_ex", bus_f.alu_op_ex, 2'b10);
      set_id(NOP, 0, 0, 0);
      tick();
      chk("ld_reg_write_wb", bus_f.reg_write_wb, 1);
      chk("ld_mem_2_reg_wb", bus_f.mem_2_reg_wb, 1);
      chk("ld_rd_wb", bus_f.rd_wb, 5);
      chk("r_mem_read_mem", bus_f.mem_read_mem, 0);
      drain();

      // load-use: LOAD rd=3, R rs1=3 stalls one cycle then forwards from MEM/WB
      set_id(LD, 3, 1, 0);
      tick();
      set_id(R, 9, 3, 4);
      chk("lu_pc_write", bus_f.pc_write, 0);
      chk("lu_if_id_write", bus_f.if_id_write, 0);
      chk("lu_if_id_flush", bus_f.if_id_flush, 0);
      tick();
      chk("lu_bubble_alu_op", bus_f.alu_op_ex, 0);
      chk("lu_bubble_alu_src", bus_f.alu_src_ex, 0);
      chk("lu_pc_write_after", bus_f.pc_write, 1);
      chk("lu_mem_read_mem", bus_f.mem_read_mem, 1);
      tick();
      chk("lu_r_alu_op", bus_f.alu_op_ex, 2'b10);
      chk("lu_fwd_a", bus_f.forward_a_ex, 2'b01);
      chk("lu_fwd_b", bus_f.forward_b_ex, 2'b00);

      // forward priority: two writers of x7, then a reader of rs2=7
      set_id(R, 7, 0, 0);
      tick();
      set_id(R, 7, 0, 0);
      tick();
      set_id(R, 10, 0, 7);
      tick();
      chk("prio_fwd_b", bus_f.forward_b_ex, 2'b10);
      chk("prio_fwd_a", bus_f.forward_a_ex, 2'b00);
      chk("prio_rd_wb", bus_f.rd_wb, 7);
      drain();

      // flush in the same cycle as a load-use
      set_id(LD, 3, 0, 0);
      tick();
      set_id(R, 9, 3, 0);
      flush = 1'b1;
      #1;
      chk("fl_if_id_flush", bus_f.if_id_flush, 1);
      chk("fl_pc_write", bus_f.pc_write, 1);
      chk("fl_if_id_write", bus_f.if_id_write, 1);
      tick();
      flush = 1'b0;
      set_id(NOP, 0, 0, 0);
      chk("fl_alu_op", bus_f.alu_op_ex, 0);
      chk("fl_alu_src", bus_f.alu_src_ex, 0);
      chk("fl_branch", bus_f.branch_ex, 0);
      chk("fl_jump", bus_f.jump_ex, 0);
      drain();

      // x0 never stalls
      set_id(LD, 0, 1, 0);
      tick();
      set_id(R, 5, 0, 0);
      chk("x0_pc_write", bus_f.pc_write, 1);
      chk("x0_n_pc_write", bus_n.pc_write, 1);
      tick();

      // illegal opcode, BEQ, JAL, STORE through the pipe
      set_id(ILL, 6, 0, 0);
      tick();
      chk("ill_alu_op", bus_f.alu_op_ex, 0);
      chk("ill_alu_src", bus_f.alu_src_ex, 0);
      set_id(BEQ, 0, 0, 0);
      tick();
      chk("beq_branch", bus_f.branch_ex, 1);
      chk("beq_alu_op", bus_f.alu_op_ex, 2'b01);
      set_id(JAL, 1, 0, 0);
      tick();
      chk("jal_jump", bus_f.jump_ex, 1);
      chk("jal_alu_op", bus_f.alu_op_ex, 0);
      chk("ill_reg_write_wb", bus_f.reg_write_wb, 0);
      set_id(ST, 0, 0, 0);
      tick();
      chk("st_alu_src", bus_f.alu_src_ex, 1);
      chk("beq_reg_write_wb", bus_f.reg_write_wb, 0);
      set_id(NOP, 0, 0, 0);
      tick();
      chk("st_mem_write_mem", bus_f.mem_write_mem, 1);
      chk("jal_reg_write_wb", bus_f.reg_write_wb, 1);
      chk("jal_rd_wb", bus_f.rd_wb, 1);
      chk("jal_mem_2_reg_wb", bus_f.mem_2_reg_wb, 0);
      drain();

      // enable=0 freezes every stage
      set_id(I, 2, 0, 0);
      tick();
      chk("i_alu_src", bus_f.alu_src_ex, 1);
      enable = 1'b0;
      set_id(R, 3, 0, 0);
      tick();
      chk("hold_alu_src", bus_f.alu_src_ex, 1);
      chk("hold_alu_op", bus_f.alu_op_ex, 0);
      enable = 1'b1;
      drain();

      // FWD_EN=0: R rd=4 then reader of x4 stalls two cycles
      set_id(R, 4, 0, 0);
      tick();
      set_id(R, 8, 4, 0);
      chk("nf_pc_write_1", bus_n.pc_write, 0);
      chk("nf_if_id_write_1", bus_n.if_id_write, 0);
      tick();
      chk("nf_pc_write_2", bus_n.pc_write, 0);
      chk("nf_bubble_alu_op", bus_n.alu_op_ex, 0);
      tick();
      chk("nf_pc_write_3", bus_n.pc_write, 1);
      tick();
      set_id(NOP, 0, 0, 0);
      chk("nf_r_alu_op", bus_n.alu_op_ex, 2'b10);
      chk("nf_fwd_a", bus_n.forward_a_ex, 2'b00);
      drain();

      // asynchronous reset while a load-use stall is active
      set_id(LD, 3, 0, 0);
      tick();
      set_id(R, 9, 3, 0);
      chk("mid_pc_write", bus_f.pc_write, 0);
      chk("mid_alu_src", bus_f.alu_src_ex, 1);
      arst_n = 1'b0;
      #1;
      chk("arst_pc_write", bus_f.pc_write, 1);
      chk("arst_if_id_write", bus_f.if_id_write, 1);
      chk("arst_alu_src", bus_f.alu_src_ex, 0);
      chk("arst_n_pc_write", bus_n.pc_write, 1);
      tick();
      arst_n = 1'b1;
      set_id(NOP, 0, 0, 0);
      tick();
      chk("post_rst_pc_write", bus_f.pc_write, 1);
      chk("post_rst_alu_src", bus_f.alu_src_ex, 0);
      chk("post_rst_mem_read", bus_f.mem_read_mem, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
